// File: rtl/rv32i_pkg.sv
// ============================================================================
//  rv32i_pkg
//  Shared types and constants for the RV32I fetch stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package rv32i_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      FS_IDLE = 3'd0,
      FS_REQ  = 3'd1,
      FS_WAIT = 3'd2,
      FS_HOLD = 3'd3,
      FS_HALT = 3'd4
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_register.sv
// ============================================================================
//  pc_register
//  Program counter: loads a redirect target or steps by one word.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pc_register
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_en,
   input  logic [XLEN-1:0] load_pc,
   input  logic            inc_en,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_next
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   // A load always wins over an increment; the add wraps modulo 2^32.
   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = load_pc;
      end else if (inc_en) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc      = pc_q;
   assign pc_next = pc_d;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
//  instruction_fetch
//  RV32I fetch stage: single-outstanding imem handshake, valid/ready output,
//  redirect flush. Optional macro FETCH_MISALIGN_TRAP_EN halts on a
//  misaligned redirect target.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic            fetch_misaligned
);

   fetch_state_t    state_q, state_d;
   logic            kill_q, kill_d;
   logic            imem_req_q, imem_req_d;
   logic [XLEN-1:0] imem_addr_q, imem_addr_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] if_instr_q, if_instr_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic            misaligned_q, misaligned_d;

   logic            pc_load;
   logic            pc_inc;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] target_pc;
   logic            misalign_hit;

   assign target_pc = redirect_pc & ~32'h0000_0003;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign_hit = (redirect_pc[1:0] != 2'b00);
`else
   assign misalign_hit = 1'b0;
`endif

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_en (pc_load),
      .load_pc (target_pc),
      .inc_en  (pc_inc),
      .pc      (pc),
      .pc_next (pc_next)
   );

   always_comb begin
      state_d      = state_q;
      kill_d       = kill_q;
      if_valid_d   = if_valid_q;
      if_instr_d   = if_instr_q;
      if_pc_d      = if_pc_q;
      misaligned_d = misaligned_q;
      pc_load      = 1'b0;
      pc_inc       = 1'b0;

      case (state_q)
         FS_IDLE: state_d = FS_REQ;
         FS_REQ: begin
            if (imem_gnt) state_d = FS_WAIT;
         end
         FS_WAIT: begin
            if (imem_rvalid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = FS_REQ;
               end else begin
                  if_instr_d = imem_rdata;
                  if_pc_d    = pc;
                  if_valid_d = 1'b1;
                  pc_inc     = 1'b1;
                  state_d    = FS_HOLD;
               end
            end
         end
         FS_HOLD: begin
            if (if_ready) begin
               if_valid_d = 1'b0;
               state_d    = FS_REQ;
            end
         end
         FS_HALT: state_d = FS_HALT;
         default: state_d = FS_IDLE;
      endcase

      // Redirect overrides all of the above; a request already granted keeps
      // its response pending, so kill marks it for discard.
      if (redirect_valid && (state_q != FS_HALT)) begin
         if_valid_d = 1'b0;
         if_instr_d = if_instr_q;
         if_pc_d    = if_pc_q;
         pc_inc     = 1'b0;
         if (misalign_hit) begin
            misaligned_d = 1'b1;
            state_d      = FS_HALT;
         end else begin
            pc_load = 1'b1;
            if ((state_q == FS_REQ) && imem_gnt) begin
               kill_d  = 1'b1;
               state_d = FS_WAIT;
            end else if ((state_q == FS_WAIT) && !imem_rvalid) begin
               kill_d  = 1'b1;
               state_d = FS_WAIT;
            end else begin
               kill_d  = 1'b0;
               state_d = FS_REQ;
            end
         end
      end

      imem_req_d  = (state_d == FS_REQ);
      imem_addr_d = pc_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= FS_IDLE;
         kill_q       <= 1'b0;
         imem_req_q   <= 1'b0;
         imem_addr_q  <= RESET_PC;
         if_valid_q   <= 1'b0;
         if_instr_q   <= NOP_INSTR;
         if_pc_q      <= '0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         kill_q       <= kill_d;
         imem_req_q   <= imem_req_d;
         imem_addr_q  <= imem_addr_d;
         if_valid_q   <= if_valid_d;
         if_instr_q   <= if_instr_d;
         if_pc_q      <= if_pc_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign imem_req         = imem_req_q;
   assign imem_addr        = imem_addr_q;
   assign if_valid         = if_valid_q;
   assign if_instr         = if_instr_q;
   assign if_pc            = if_pc_q;
   assign fetch_misaligned = misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
//  tb_instruction_fetch
//  Directed self-checking bench for instruction_fetch with a transfer
//  scoreboard.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        fetch_misaligned;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   instruction_fetch #(
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_gnt         (imem_gnt),
      .imem_rvalid      (imem_rvalid),
      .imem_rdata       (imem_rdata),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .if_valid         (if_valid),
      .if_ready         (if_ready),
      .if_instr         (if_instr),
      .if_pc            (if_pc),
      .fetch_misaligned (fetch_misaligned)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory responder: grant at once, respond the following cycle.
   task automatic mem_txn(input logic [31:0] a, input logic [31:0] d, input bit push,
                          output int waited);
      waited = 0;
      while (imem_req !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      chk("req_seen", {31'b0, imem_req}, 32'd1);
      chk("req_addr", imem_addr, a);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      chk("req_low_in_wait", {31'b0, imem_req}, 32'd0);
      chk("valid_low_in_wait", {31'b0, if_valid}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = d;
      if (push) sb.push_back('{pc: a, instr: d});
      step();
      imem_rvalid = 1'b0;
      chk("valid_after_rsp", {31'b0, if_valid}, 32'd1);
      chk("if_pc_after_rsp", if_pc, a);
      chk("if_instr_after_rsp", if_instr, d);
   endtask

   // Transfer monitor: every accepted instruction must match the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && if_valid === 1'b1) begin
         chk("stale_rsp_leak", {31'b0, (if_instr === 32'hDEAD_BEEF)}, 32'd0);
         if (if_ready === 1'b1 && redirect_valid !== 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $error("FAIL unexpected_xfer observed pc=%h instr=%h expected no transfer",
                      if_pc, if_instr);
            end else begin
               e = sb.pop_front();
               chk("xfer_pc", if_pc, e.pc);
               chk("xfer_instr", if_instr, e.instr);
            end
         end
      end
   end

   initial begin
      int w;
      rst_n          = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      if_ready       = 1'b0;
      repeat (3) step();

      chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
      chk("rst_imem_addr", imem_addr, 32'h0000_0000);
      chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_if_instr", if_instr, 32'h0000_0013);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_misaligned", {31'b0, fetch_misaligned}, 32'd0);

      // Basic fetch: IDLE, then back-to-back fetches with if_ready high
      rst_n    = 1'b1;
      if_ready = 1'b1;
      chk("idle_no_req", {31'b0, imem_req}, 32'd0);
      step();
      chk("first_req", {31'b0, imem_req}, 32'd1);
      mem_txn(32'h0000_0000, 32'h0010_0093, 1'b1, w);
      chk("first_req_wait", w, 32'd0);
      mem_txn(32'h0000_0004, 32'h0020_0113, 1'b1, w);
      chk("second_req_wait", w, 32'd1);

      // HOLD stall: held instruction stable, no new request, no pc advance
      if_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", {31'b0, if_valid}, 32'd1);
         chk("stall_instr", if_instr, 32'h0020_0113);
         chk("stall_pc", if_pc, 32'h0000_0004);
         chk("stall_req", {31'b0, imem_req}, 32'd0);
      end
      if_ready = 1'b1;
      step();
      chk("after_stall_req", {31'b0, imem_req}, 32'd1);
      chk("after_stall_addr", imem_addr, 32'h0000_0008);

      // Redirect while WAIT: pending response discarded
      imem_gnt = 1'b1;
      step();
      imem_gnt       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      step();
      redirect_valid = 1'b0;
      chk("wait_redir_req", {31'b0, imem_req}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      step();
      imem_rvalid = 1'b0;
      chk("wait_redir_valid", {31'b0, if_valid}, 32'd0);
      chk("wait_redir_addr", imem_addr, 32'h0000_0100);
      mem_txn(32'h0000_0100, 32'h0030_0193, 1'b1, w);

      // Redirect in the same cycle as gnt
      step();
      chk("pre_gnt_redir_addr", imem_addr, 32'h0000_0104);
      imem_gnt       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      step();
      imem_gnt       = 1'b0;
      redirect_valid = 1'b0;
      chk("gnt_redir_req", {31'b0, imem_req}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      step();
      imem_rvalid = 1'b0;
      chk("gnt_redir_valid", {31'b0, if_valid}, 32'd0);
      chk("gnt_redir_addr", imem_addr, 32'h0000_0200);
      mem_txn(32'h0000_0200, 32'h0040_0213, 1'b1, w);

      // PC wrap at the top of the address space
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      mem_txn(32'hFFFF_FFFC, 32'h0050_0293, 1'b1, w);
      step();
      chk("wrap_addr", imem_addr, 32'h0000_0000);

      // Redirect while HOLD with if_ready high: held instruction flushed
      mem_txn(32'h0000_0000, 32'h0060_0313, 1'b0, w);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0300;
      step();
      redirect_valid = 1'b0;
      chk("flush_valid", {31'b0, if_valid}, 32'd0);
      chk("flush_req", {31'b0, imem_req}, 32'd1);
      chk("flush_addr", imem_addr, 32'h0000_0300);

      // Misaligned redirect target
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0102;
      step();
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis_flag", {31'b0, fetch_misaligned}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         redirect_valid = (i == 1);
         redirect_pc    = 32'h0000_0400;
         step();
         chk("halt_req", {31'b0, imem_req}, 32'd0);
         chk("halt_valid", {31'b0, if_valid}, 32'd0);
         chk("halt_flag", {31'b0, fetch_misaligned}, 32'd1);
      end
      redirect_valid = 1'b0;
      rst_n = 1'b0;
      step();
      chk("halt_rst_flag", {31'b0, fetch_misaligned}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("halt_rst_req", {31'b0, imem_req}, 32'd1);
      chk("halt_rst_addr", imem_addr, 32'h0000_0000);
`else
      chk("mis_flag", {31'b0, fetch_misaligned}, 32'd0);
      chk("mis_req", {31'b0, imem_req}, 32'd1);
      chk("mis_addr", imem_addr, 32'h0000_0100);
      mem_txn(32'h0000_0100, 32'h0070_0393, 1'b1, w);
      step();
`endif
      chk("sb_drained", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
